fu_issue_ctrl: RTL and testbench
================================

FU_ISSUE_CTRL -- requirements
Module: fu_issue_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, lane width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles in BUSY before abort (1..255).
REQ-003 SHALL have port clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 SHALL have port reset  in  1  synchronous active-high reset.
REQ-005 SHALL have port op_valid  in  1  upstream operand bundle valid.
REQ-006 SHALL have port op_ready  out  1  controller can accept a bundle.
REQ-007 SHALL have port op_data  in  8*WIDTH  operands; lane k = bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port cfg_in  in  16  [1:0] mode (0=4x16, 1=2x32, 3=1x64, 2=illegal); [3:2] destination (0=N, 1=E, 2=S, 3=W); [15:4] reserved, ignored.
REQ-009 SHALL have port fu_inputs  out  8*WIDTH  operands driven to adder FU.
REQ-010 SHALL have port fu_config  out  16  config word driven to adder FU.
REQ-011 SHALL have port fu_on_off  out  1  FU enable.
REQ-012 SHALL have port fu_ack  in  1  FU completion acknowledge.
REQ-013 SHALL have port fu_outputs  in  4*WIDTH  FU result lanes, lane 0 at LSB.
REQ-014 SHALL have port res_valid  out  4  one-hot per neighbor (bit 0=N .. bit 3=W).
REQ-015 SHALL have port res_ready  in  4  per-neighbor ready.
REQ-016 SHALL have port res_data  out  4*WIDTH  captured result, shared by all neighbors.
REQ-017 SHALL have port res_mode  out  2  mode of the result in res_data.
REQ-018 SHALL have port err  out  1  single-cycle pulse on illegal mode or timeout.
REQ-019 SHALL have port ops_done  out  16  saturating count of results delivered.

Function
REQ-020 SHALL implement FSM states IDLE, BUSY, SEND.
REQ-021 op_ready SHALL be 1 only in IDLE with fu_ack=0, else 0.
REQ-022 IDLE: on op_valid&&op_ready with legal mode, SHALL register op_data into fu_inputs and cfg_in into fu_config, then go to BUSY next cycle.
REQ-023 IDLE: on handshake with mode=2, SHALL drop the bundle, pulse err for 1 cycle, stay IDLE, leave fu_inputs/fu_config unchanged.
REQ-024 BUSY: fu_on_off SHALL be 1 for every cycle in BUSY and 0 in all other states.
REQ-025 BUSY: first cycle fu_ack=1 sampled SHALL capture fu_outputs into res_data and fu_config[1:0] into res_mode, then go to SEND.
REQ-026 SEND: res_valid SHALL be one-hot at bit fu_config[3:2], all other bits 0; res_data/res_mode SHALL hold stable while valid.
REQ-027 SEND: on res_valid[d]&&res_ready[d] SHALL clear res_valid, increment ops_done (saturate at 0xFFFF), go to IDLE next cycle.
REQ-028 Ready on non-selected neighbors SHALL be ignored.
REQ-029 Minimum cycle per op SHALL be: accept (1) + BUSY (FU latency) + SEND (1 if ready high).
REQ-030 A new bundle SHALL NOT be accepted while fu_ack remains high after SEND (prevents stale-ack capture).

Reset
REQ-031 On reset SHALL enter IDLE; fu_on_off=0, res_valid=0, res_data=0, res_mode=0, fu_inputs=0, fu_config=0, err=0, ops_done=0, timeout counter=0.
REQ-032 op_ready SHALL be 0 in any cycle reset is asserted.
REQ-033 Reset mid-BUSY or mid-SEND SHALL abort the op with no err pulse and no ops_done increment.

Configuration
REQ-034 Macro FU_ISSUE_TIMEOUT_EN: defined -> BUSY counts cycles from entry; if fu_ack not seen within TIMEOUT cycles, drop op, pulse err, go to IDLE, fu_on_off low next cycle.
REQ-035 FU_ISSUE_TIMEOUT_EN undefined -> no counter, BUSY waits indefinitely, err only from illegal mode; TIMEOUT unused.

Verification
REQ-036 Mode 0, dest E, lanes 1..8, FU acks after 2 cycles, res_ready=4'b0010 -> res_valid=4'b0010, res_data={15,11,7,3} (lane3..0), ops_done=1.
REQ-037 Mode 3, dest W, res_ready low 5 cycles -> res_valid=4'b1000 held 5 cycles, res_data stable, op_ready=0 throughout.
REQ-038 cfg_in[1:0]=2 with op_valid=1 -> err high exactly 1 cycle, fu_on_off never asserts, op_ready stays 1.
REQ-039 With FU_ISSUE_TIMEOUT_EN, TIMEOUT=15, fu_ack held 0 -> fu_on_off high 15 cycles, err pulses, IDLE; without macro fu_on_off stays high.
REQ-040 Reset asserted 2 cycles into BUSY -> next cycle all outputs at reset values, ops_done unchanged at 0.
REQ-041 fu_ack held high after SEND completes, op_valid=1 -> op_ready=0 until fu_ack falls, then bundle accepted.

Source files
------------

// File: rtl/fu_issue_ctrl.sv
// Issue controller: hands operand bundles to an adder FU and routes the result to one neighbor.
// Optional BUSY watchdog enabled by defining FU_ISSUE_TIMEOUT_EN.
module fu_issue_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [8*WIDTH-1:0]   op_data,
  input  logic [15:0]          cfg_in,
  output logic [8*WIDTH-1:0]   fu_inputs,
  output logic [15:0]          fu_config,
  output logic                 fu_on_off,
  input  logic                 fu_ack,
  input  logic [4*WIDTH-1:0]   fu_outputs,
  output logic [3:0]           res_valid,
  input  logic [3:0]           res_ready,
  output logic [4*WIDTH-1:0]   res_data,
  output logic [1:0]           res_mode,
  output logic                 err,
  output logic [15:0]          ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [8*WIDTH-1:0]   fu_inputs_q, fu_inputs_d;
  logic [15:0]          fu_config_q, fu_config_d;
  logic [4*WIDTH-1:0]   res_data_q, res_data_d;
  logic [1:0]           res_mode_q, res_mode_d;
  logic                 err_q, err_d;
  logic [15:0]          ops_done_q, ops_done_d;

`ifdef FU_ISSUE_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);
  logic [7:0]           tmo_q, tmo_d;
`else
  localparam int        tmo_unused = TIMEOUT;
`endif

  // Ack still high from the previous op must not be mistaken for a new one
  assign op_ready  = (state_q == IDLE) && !fu_ack && !reset;
  assign fu_on_off = (state_q == BUSY);
  assign fu_inputs = fu_inputs_q;
  assign fu_config = fu_config_q;
  assign res_data  = res_data_q;
  assign res_mode  = res_mode_q;
  assign err       = err_q;
  assign ops_done  = ops_done_q;

  always_comb begin
    res_valid = 4'b0000;
    if (state_q == SEND) res_valid[fu_config_q[3:2]] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    fu_inputs_d = fu_inputs_q;
    fu_config_d = fu_config_q;
    res_data_d  = res_data_q;
    res_mode_d  = res_mode_q;
    err_d       = 1'b0;
    ops_done_d  = ops_done_q;
`ifdef FU_ISSUE_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef FU_ISSUE_TIMEOUT_EN
        tmo_d = 8'd0;
`endif
        if (op_valid && op_ready) begin
          if (cfg_in[1:0] == 2'd2) begin
            err_d = 1'b1;
          end else begin
            fu_inputs_d = op_data;
            fu_config_d = cfg_in;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        if (fu_ack) begin
          res_data_d = fu_outputs;
          res_mode_d = fu_config_q[1:0];
          state_d    = SEND;
        end
`ifdef FU_ISSUE_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      SEND: begin
        if (res_ready[fu_config_q[3:2]]) begin
          if (ops_done_q != 16'hFFFF) ops_done_d = ops_done_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fu_inputs_q <= '0;
      fu_config_q <= '0;
      res_data_q  <= '0;
      res_mode_q  <= '0;
      err_q       <= 1'b0;
      ops_done_q  <= '0;
`ifdef FU_ISSUE_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fu_inputs_q <= fu_inputs_d;
      fu_config_q <= fu_config_d;
      res_data_q  <= res_data_d;
      res_mode_q  <= res_mode_d;
      err_q       <= err_d;
      ops_done_q  <= ops_done_d;
`ifdef FU_ISSUE_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Directed bench for fu_issue_ctrl; the adder FU is stubbed as pairwise lane sums.
// Timeout expectations follow FU_ISSUE_TIMEOUT_EN.
module tb_fu_issue_ctrl;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           op_valid;
  logic           op_ready;
  logic [8*W-1:0] op_data;
  logic [15:0]    cfg_in;
  logic [8*W-1:0] fu_inputs;
  logic [15:0]    fu_config;
  logic           fu_on_off;
  logic           fu_ack;
  logic [4*W-1:0] fu_outputs;
  logic [3:0]     res_valid;
  logic [3:0]     res_ready;
  logic [4*W-1:0] res_data;
  logic [1:0]     res_mode;
  logic           err;
  logic [15:0]    ops_done;

  int n_chk  = 0;
  int n_pass = 0;

  fu_issue_ctrl #(.WIDTH(W), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_data    (op_data),
    .cfg_in     (cfg_in),
    .fu_inputs  (fu_inputs),
    .fu_config  (fu_config),
    .fu_on_off  (fu_on_off),
    .fu_ack     (fu_ack),
    .fu_outputs (fu_outputs),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_mode   (res_mode),
    .err        (err),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    fu_outputs = '0;
    for (int k = 0; k < 4; k++)
      fu_outputs[k*W +: W] = fu_inputs[2*k*W +: W]
                           + fu_inputs[(2*k+1)*W +: W];
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8*W-1:0] lanes(input int b);
    logic [8*W-1:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*W +: W] = 16'(b + i);
    return v;
  endfunction

  int n_on;
  int n_err;
  logic [4*W-1:0] held;

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_data = '0;
    cfg_in = '0; fu_ack = 1'b0; res_ready = '0;
    tick(); tick();
    chk("rst_op_ready", op_ready, 0);
    chk("rst_on_off", fu_on_off, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    #1 chk("idle_ready", op_ready, 1);

    // mode 0, dest E, FU acks on 2nd BUSY cycle
    op_valid = 1'b1; op_data = lanes(1); cfg_in = 16'h0004;
    res_ready = 4'b0010;
    tick();
    op_valid = 1'b0;
    chk("m0_on_off", fu_on_off, 1);
    chk("m0_inputs", fu_inputs, lanes(1));
    chk("m0_config", fu_config, 16'h0004);
    chk("m0_busy_ready", op_ready, 0);
    tick();
    fu_ack = 1'b1;
    tick();
    fu_ack = 1'b0;
    chk("m0_valid", res_valid, 4'b0010);
    chk("m0_data", res_data, {16'd15, 16'd11, 16'd7, 16'd3});
    chk("m0_mode", res_mode, 0);
    chk("m0_send_off", fu_on_off, 0);
    tick();
    chk("m0_valid_clr", res_valid, 0);
    chk("m0_ops_done", ops_done, 1);

    // mode 3, dest W, selected ready low for 5 cycles
    op_valid = 1'b1; op_data = lanes(16); cfg_in = 16'h000F;
    res_ready = 4'b0111;
    tick();
    op_valid = 1'b0; fu_ack = 1'b1;
    tick();
    fu_ack = 1'b0;
    held = {16'd45, 16'd41, 16'd37, 16'd33};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk("m3_valid_hold", res_valid, 4'b1000);
      chk("m3_data_hold", res_data, held);
      chk("m3_ready_low", op_ready, 0);
    end
    chk("m3_mode", res_mode, 3);
    res_ready = 4'b1000;
    tick();
    chk("m3_valid_clr", res_valid, 0);
    chk("m3_ops_done", ops_done, 2);
    res_ready = 4'b0000;

    // illegal mode is dropped with a one-cycle err
    op_valid = 1'b1; op_data = lanes(100); cfg_in = 16'h0002;
    #1 chk("ill_ready", op_ready, 1);
    tick();
    op_valid = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_on_off", fu_on_off, 0);
    chk("ill_ready_after", op_ready, 1);
    chk("ill_config", fu_config, 16'h000F);
    chk("ill_inputs", fu_inputs, lanes(16));
    tick();
    chk("ill_err_clr", err, 0);
    chk("ill_ops_done", ops_done, 2);

    // ack held high across SEND blocks the next bundle
    op_valid = 1'b1; op_data = lanes(32); cfg_in = 16'h0000;
    res_ready = 4'b0001;
    tick();
    op_valid = 1'b0; fu_ack = 1'b1;
    tick();
    chk("ack_valid", res_valid, 4'b0001);
    tick();
    chk("ack_ops_done", ops_done, 3);
    op_valid = 1'b1; op_data = lanes(48);
    #1 chk("ack_block", op_ready, 0);
    tick();
    chk("ack_not_taken", fu_on_off, 0);
    fu_ack = 1'b0;
    #1 chk("ack_release", op_ready, 1);
    tick();
    op_valid = 1'b0;
    chk("ack_taken", fu_on_off, 1);
    chk("ack_inputs", fu_inputs, lanes(48));

    // reset two cycles into BUSY
    tick();
    reset = 1'b1;
    tick();
    chk("abort_on_off", fu_on_off, 0);
    chk("abort_valid", res_valid, 0);
    chk("abort_data", res_data, 0);
    chk("abort_mode", res_mode, 0);
    chk("abort_inputs", fu_inputs, 0);
    chk("abort_config", fu_config, 0);
    chk("abort_err", err, 0);
    chk("abort_ops_done", ops_done, 0);
    chk("abort_ready", op_ready, 0);
    reset = 1'b0;
    tick();

    // FU never acks
    op_valid = 1'b1; op_data = lanes(1); cfg_in = 16'h0004;
    tick();
    op_valid = 1'b0;
    n_on = 0; n_err = 0;
    for (int i = 0; i < 30; i++) begin
      if (fu_on_off) n_on++;
      if (err) n_err++;
      tick();
    end
`ifdef FU_ISSUE_TIMEOUT_EN
    chk("tmo_on_cycles", n_on, 15);
    chk("tmo_err_pulses", n_err, 1);
    chk("tmo_idle", op_ready, 1);
`else
    chk("notmo_on_cycles", n_on, 30);
    chk("notmo_err", n_err, 0);
    chk("notmo_still_on", fu_on_off, 1);
`endif
    chk("tmo_ops_done", ops_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
